// File: rtl/zone_check_pkg.sv
// Shared types for the per-frame player safe-zone check: FSM states and the
// corner walk order (TL, TR, BL, BR) used to probe the safe-zone map.
package zone_check_pkg;

  typedef enum logic [3:0] {
    ZC_IDLE,
    ZC_Q0,
    ZC_S0,
    ZC_Q1,
    ZC_S1,
    ZC_Q2,
    ZC_S2,
    ZC_Q3,
    ZC_S3,
    ZC_DONE
  } zc_state_t;

  typedef logic [1:0] corner_t;

  localparam corner_t CORNER_TL = 2'd0;
  localparam corner_t CORNER_TR = 2'd1;
  localparam corner_t CORNER_BL = 2'd2;
  localparam corner_t CORNER_BR = 2'd3;

  // Bit 0 selects the right edge, bit 1 the bottom edge of the sprite.
  function automatic logic corner_right(input corner_t k);
    return k[0];
  endfunction

  function automatic logic corner_bottom(input corner_t k);
    return k[1];
  endfunction

endpackage

// File: rtl/player_zone_checker.sv
// Probes the four sprite corners against the safe-zone map once per frame and
// pulses o_dead after DEATH_FRAMES consecutive unsafe checks.
module player_zone_checker
  import zone_check_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int PLAYER_SIZE   = 20,
  parameter int DEATH_FRAMES  = 3
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic                             i_frame_tick,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  i_player_x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] i_player_y,
  input  logic                             i_zone_rdy,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  o_query_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] o_query_y,
  input  logic                             i_is_safe,
  output logic                             o_busy,
  output logic                             o_check_valid,
  output logic                             o_on_safe,
  output logic                             o_dead
);

  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam int CW = $clog2(DEATH_FRAMES + 1);

  localparam logic [XW:0]   X_ADD     = (XW + 1)'(PLAYER_SIZE - 1);
  localparam logic [YW:0]   Y_ADD     = (YW + 1)'(PLAYER_SIZE - 1);
  localparam logic [XW:0]   X_MAX     = (XW + 1)'(SCREEN_WIDTH - 1);
  localparam logic [YW:0]   Y_MAX     = (YW + 1)'(SCREEN_HEIGHT - 1);
  localparam logic [CW-1:0] DEATH_CNT = CW'(DEATH_FRAMES);

  zc_state_t     state_reg;
  logic [XW-1:0] px_reg;
  logic [YW-1:0] py_reg;
  logic          all_safe_reg;
  logic [CW-1:0] cnt_reg;
  logic [XW-1:0] query_x_reg;
  logic [YW-1:0] query_y_reg;
  logic          busy_reg;
  logic          check_valid_reg;
  logic          on_safe_reg;
  logic          dead_reg;

  logic [XW:0]   x_sum;
  logic [YW:0]   y_sum;
  logic [XW-1:0] x1;
  logic [YW-1:0] y1;
  corner_t       next_corner;
  logic [XW-1:0] corner_x;
  logic [YW-1:0] corner_y;
  logic [CW-1:0] cnt_inc;
  logic          final_safe;

  // Far edges are computed one bit wider so the clamp sees the true sum.
  assign x_sum = {1'b0, px_reg} + X_ADD;
  assign y_sum = {1'b0, py_reg} + Y_ADD;
  assign x1    = (x_sum > X_MAX) ? X_MAX[XW-1:0] : x_sum[XW-1:0];
  assign y1    = (y_sum > Y_MAX) ? Y_MAX[YW-1:0] : y_sum[YW-1:0];

  always_comb begin
    next_corner = CORNER_TL;
    case (state_reg)
      ZC_S0:   next_corner = CORNER_TR;
      ZC_S1:   next_corner = CORNER_BL;
      ZC_S2:   next_corner = CORNER_BR;
      default: next_corner = CORNER_TL;
    endcase
  end

  assign corner_x   = corner_right(next_corner)  ? x1 : px_reg;
  assign corner_y   = corner_bottom(next_corner) ? y1 : py_reg;
  assign cnt_inc    = cnt_reg + CW'(1);
  assign final_safe = all_safe_reg & i_is_safe;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_reg       <= ZC_IDLE;
      px_reg          <= '0;
      py_reg          <= '0;
      all_safe_reg    <= 1'b1;
      cnt_reg         <= '0;
      query_x_reg     <= '0;
      query_y_reg     <= '0;
      busy_reg        <= 1'b0;
      check_valid_reg <= 1'b0;
      on_safe_reg     <= 1'b1;
      dead_reg        <= 1'b0;
    end else begin
      check_valid_reg <= 1'b0;
      dead_reg        <= 1'b0;
      case (state_reg)
        ZC_IDLE: begin
          if (i_frame_tick) begin
            if (i_zone_rdy) begin
              px_reg       <= i_player_x;
              py_reg       <= i_player_y;
              query_x_reg  <= i_player_x;
              query_y_reg  <= i_player_y;
              all_safe_reg <= 1'b1;
              busy_reg     <= 1'b1;
              state_reg    <= ZC_Q0;
            end else begin
              cnt_reg <= '0;
            end
          end
        end
        ZC_Q0, ZC_Q1, ZC_Q2, ZC_Q3: begin
          if (!i_zone_rdy) begin
            busy_reg  <= 1'b0;
            state_reg <= ZC_IDLE;
          end else begin
            case (state_reg)
              ZC_Q0:   state_reg <= ZC_S0;
              ZC_Q1:   state_reg <= ZC_S1;
              ZC_Q2:   state_reg <= ZC_S2;
              default: state_reg <= ZC_S3;
            endcase
          end
        end
        ZC_S0, ZC_S1, ZC_S2: begin
          if (!i_zone_rdy) begin
            busy_reg  <= 1'b0;
            state_reg <= ZC_IDLE;
          end else begin
            all_safe_reg <= final_safe;
            query_x_reg  <= corner_x;
            query_y_reg  <= corner_y;
            case (state_reg)
              ZC_S0:   state_reg <= ZC_Q1;
              ZC_S1:   state_reg <= ZC_Q2;
              default: state_reg <= ZC_Q3;
            endcase
          end
        end
        ZC_S3: begin
          if (!i_zone_rdy) begin
            busy_reg  <= 1'b0;
            state_reg <= ZC_IDLE;
          end else begin
            check_valid_reg <= 1'b1;
            on_safe_reg     <= final_safe;
            all_safe_reg    <= final_safe;
            if (final_safe) begin
              cnt_reg <= '0;
            end else if (cnt_inc == DEATH_CNT) begin
              dead_reg <= 1'b1;
              cnt_reg  <= '0;
            end else begin
              cnt_reg <= cnt_inc;
            end
            state_reg <= ZC_DONE;
          end
        end
        ZC_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ZC_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ZC_IDLE;
        end
      endcase
    end
  end

  assign o_query_x     = query_x_reg;
  assign o_query_y     = query_y_reg;
  assign o_busy        = busy_reg;
  assign o_check_valid = check_valid_reg;
  assign o_on_safe     = on_safe_reg;
  assign o_dead        = dead_reg;

endmodule

// File: tb/tb_player_zone_checker.sv
// Randomized bench for player_zone_checker: a rectangle-plus-hole safe-zone map
// answers queries, and a frame-level model predicts every output cycle by cycle.
module tb_player_zone_checker;

  localparam int SW = 800;
  localparam int SH = 600;
  localparam int PS = 20;
  localparam int DF = 3;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       i_frame_tick;
  logic [9:0] i_player_x;
  logic [9:0] i_player_y;
  logic       i_zone_rdy;
  logic [9:0] o_query_x;
  logic [9:0] o_query_y;
  logic       i_is_safe;
  logic       o_busy;
  logic       o_check_valid;
  logic       o_on_safe;
  logic       o_dead;

  always #5 clk = ~clk;

  player_zone_checker #(
    .SCREEN_WIDTH (SW),
    .SCREEN_HEIGHT(SH),
    .PLAYER_SIZE  (PS),
    .DEATH_FRAMES (DF)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_frame_tick (i_frame_tick),
    .i_player_x   (i_player_x),
    .i_player_y   (i_player_y),
    .i_zone_rdy   (i_zone_rdy),
    .o_query_x    (o_query_x),
    .o_query_y    (o_query_y),
    .i_is_safe    (i_is_safe),
    .o_busy       (o_busy),
    .o_check_valid(o_check_valid),
    .o_on_safe    (o_on_safe),
    .o_dead       (o_dead)
  );

  // Safe-zone map: inside [zx0..zx1]x[zy0..zy1], minus one optional bad pixel.
  int zx0, zx1, zy0, zy1, bad_x, bad_y;

  always_comb begin
    i_is_safe = (int'(o_query_x) >= zx0) && (int'(o_query_x) <= zx1) &&
                (int'(o_query_y) >= zy0) && (int'(o_query_y) <= zy1) &&
                !((int'(o_query_x) == bad_x) && (int'(o_query_y) == bad_y));
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_frames = 0;
  int   exp_cnt  = 0;
  logic exp_on_safe = 1'b1;
  int   exp_qx = 0;
  int   exp_qy = 0;

  function automatic bit zone_safe(input int x, input int y);
    return (x >= zx0) && (x <= zx1) && (y >= zy0) && (y <= zy1) &&
           !((x == bad_x) && (y == bad_y));
  endfunction

  function automatic int corner_x(input int px, input int k);
    if (k % 2 == 1) return (px + PS - 1 > SW - 1) ? SW - 1 : px + PS - 1;
    return px;
  endfunction

  function automatic int corner_y(input int py, input int k);
    if (k >= 2) return (py + PS - 1 > SH - 1) ? SH - 1 : py + PS - 1;
    return py;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_zone(input int x0, input int x1, input int y0, input int y1,
                          input int bx, input int by);
    zx0 = x0; zx1 = x1; zy0 = y0; zy1 = y1; bad_x = bx; bad_y = by;
  endtask

  // One accepted tick followed by ten observed cycles; abort_at/rst_at of 0
  // means none, otherwise the cycle (1..8 / 1..9) in which rdy or reset drops.
  task automatic do_frame(input int px, input int py, input int abort_at,
                          input int rst_at, input bit overlap);
    bit   active;
    bit   abort_pend;
    bit   rst_pend;
    bit   frame_safe;
    logic exp_busy;
    logic exp_valid;
    logic exp_dead;
    logic saw_dead;
    frame_safe = 1'b1;
    for (int k = 0; k < 4; k++)
      if (!zone_safe(corner_x(px, k), corner_y(py, k))) frame_safe = 1'b0;
    @(negedge clk);
    i_player_x   = 10'(px);
    i_player_y   = 10'(py);
    i_frame_tick = 1'b1;
    @(posedge clk);
    #1;
    i_frame_tick = 1'b0;
    i_player_x   = 10'($urandom_range(0, SW - 1));
    i_player_y   = 10'($urandom_range(0, SH - 1));
    active     = 1'b1;
    abort_pend = 1'b0;
    rst_pend   = 1'b0;
    saw_dead   = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (abort_pend) begin
        active = 1'b0;
        abort_pend = 1'b0;
      end
      if (rst_pend) begin
        active      = 1'b0;
        exp_qx      = 0;
        exp_qy      = 0;
        exp_on_safe = 1'b1;
        exp_cnt     = 0;
      end
      if (active && c <= 8) begin
        exp_qx = corner_x(px, (c - 1) / 2);
        exp_qy = corner_y(py, (c - 1) / 2);
      end
      exp_valid = 1'b0;
      exp_dead  = 1'b0;
      if (active && c == 9) begin
        exp_valid   = 1'b1;
        exp_on_safe = frame_safe;
        if (frame_safe) exp_cnt = 0;
        else begin
          exp_cnt++;
          if (exp_cnt == DF) begin
            exp_dead = 1'b1;
            exp_cnt  = 0;
          end
        end
      end
      exp_busy = active && (c <= 9);
      check_eq("busy",    o_busy,        exp_busy);
      check_eq("valid",   o_check_valid, exp_valid);
      check_eq("dead",    o_dead,        exp_dead);
      check_eq("on_safe", o_on_safe,     exp_on_safe);
      check_eq("query_x", o_query_x,     exp_qx);
      check_eq("query_y", o_query_y,     exp_qy);
      if (o_dead) saw_dead = 1'b1;
      // Drive the inputs seen during the remainder of this cycle.
      if (rst_pend) begin
        arst_n   = 1'b1;
        rst_pend = 1'b0;
      end
      i_zone_rdy = 1'b1;
      if (abort_at == c) begin
        i_zone_rdy = 1'b0;
        abort_pend = 1'b1;
      end
      if (rst_at == c) begin
        arst_n   = 1'b0;
        rst_pend = 1'b1;
      end
      if (overlap && c == 3) begin
        i_frame_tick = 1'b1;
        i_player_x   = 10'($urandom_range(0, SW - 1));
        i_player_y   = 10'($urandom_range(0, SH - 1));
      end
      if (c == 4) i_frame_tick = 1'b0;
    end
    n_frames++;
    $display("frame %0d: pos=(%0d,%0d) abort@%0d rst@%0d overlap=%0d model_safe=%0d on_safe=%0d dead_seen=%0d",
             n_frames, px, py, abort_at, rst_at, overlap, frame_safe, o_on_safe, saw_dead);
  endtask

  // Tick while the map regenerates: ignored except for clearing the counter.
  task automatic tick_not_ready();
    @(negedge clk);
    i_zone_rdy   = 1'b0;
    i_frame_tick = 1'b1;
    @(posedge clk);
    #1;
    i_frame_tick = 1'b0;
    i_zone_rdy   = 1'b1;
    exp_cnt = 0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check_eq("nr_busy",  o_busy,        1'b0);
      check_eq("nr_valid", o_check_valid, 1'b0);
      check_eq("nr_dead",  o_dead,        1'b0);
    end
    $display("tick while zone not ready: busy=%0d", o_busy);
  endtask

  initial begin
    int px, py, ab, rs;
    bit ov;
    arst_n       = 1'b0;
    i_frame_tick = 1'b0;
    i_player_x   = '0;
    i_player_y   = '0;
    i_zone_rdy   = 1'b1;
    set_zone(0, SW - 1, 0, SH - 1, -1, -1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",    o_busy,        1'b0);
    check_eq("rst_valid",   o_check_valid, 1'b0);
    check_eq("rst_dead",    o_dead,        1'b0);
    check_eq("rst_on_safe", o_on_safe,     1'b1);
    check_eq("rst_qx",      o_query_x,     10'd0);
    check_eq("rst_qy",      o_query_y,     10'd0);
    arst_n = 1'b1;

    // All safe, then a single unsafe corner for three frames (death on the third).
    do_frame(100, 100, 0, 0, 1'b0);
    set_zone(0, SW - 1, 0, SH - 1, 119, 119);
    repeat (3) do_frame(100, 100, 0, 0, 1'b0);

    // Recovery: a safe frame between unsafe runs clears the count.
    do_frame(100, 100, 0, 0, 1'b0);
    do_frame(100, 100, 0, 0, 1'b0);
    do_frame(300, 300, 0, 0, 1'b0);
    do_frame(100, 100, 0, 0, 1'b0);
    do_frame(100, 100, 0, 0, 1'b0);

    // Regeneration clears the count too.
    tick_not_ready();
    do_frame(100, 100, 0, 0, 1'b0);
    do_frame(100, 100, 0, 0, 1'b0);

    // Edge clamp at the bottom-right of the screen.
    set_zone(0, SW - 1, 0, SH - 1, -1, -1);
    do_frame(790, 590, 0, 0, 1'b0);
    do_frame(SW - 1, SH - 1, 0, 0, 1'b0);

    // Abort mid-check, overlapping tick, reset mid-check.
    set_zone(0, SW - 1, 0, SH - 1, 100, 100);
    do_frame(100, 100, 4, 0, 1'b0);
    do_frame(100, 100, 0, 0, 1'b1);
    do_frame(100, 100, 0, 5, 1'b0);
    do_frame(100, 100, 8, 0, 1'b0);

    // Randomized frames against changing rectangular zones.
    for (int i = 0; i < 80; i++) begin
      if (i % 8 == 0) begin
        zx0 = $urandom_range(0, 300);
        zy0 = $urandom_range(0, 200);
        set_zone(zx0, zx0 + $urandom_range(40, 400), zy0, zy0 + $urandom_range(40, 300),
                 -1, -1);
      end
      if ($urandom_range(0, 1) == 1) begin
        px = zx0 + $urandom_range(0, zx1 - zx0 - PS + 1);
        py = zy0 + $urandom_range(0, zy1 - zy0 - PS + 1);
      end else begin
        px = $urandom_range(0, SW - 1);
        py = $urandom_range(0, SH - 1);
      end
      ab = 0;
      rs = 0;
      ov = 1'b0;
      case ($urandom_range(0, 19))
        0, 1:    ab = $urandom_range(1, 8);
        2:       rs = $urandom_range(1, 9);
        3, 4, 5: ov = 1'b1;
        6:       tick_not_ready();
        default: ;
      endcase
      do_frame(px, py, ab, rs, ov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/player_zone_checker.md
# player_zone_checker

Once per frame, checks whether the player's square sprite lies entirely inside the generated safe zone and raises a death pulse after a run of unsafe frames. It sits downstream of the safe-zone map: it drives that block's pixel query port (`i_x`/`i_y` → `o_is_safe`) and uses its ready flag. Results go to the game-state controller.

## Interface
- `SCREEN_WIDTH`, 800, screen width in pixels.
- `SCREEN_HEIGHT`, 600, screen height in pixels.
- `PLAYER_SIZE`, 20, player sprite side in pixels (≥1).
- `DEATH_FRAMES`, 3, consecutive unsafe checks that trigger death (≥1).

- `clk` in 1: clock.
- `arst_n` in 1: reset, synchronous, active-low.
- `i_frame_tick` in 1: one-cycle pulse at frame start.
- `i_player_x` in clog2(SCREEN_WIDTH): sprite top-left x.
- `i_player_y` in clog2(SCREEN_HEIGHT): sprite top-left y.
- `i_zone_rdy` in 1: safe-zone map valid; low while it regenerates.
- `o_query_x` out clog2(SCREEN_WIDTH): pixel x to the safe-zone map.
- `o_query_y` out clog2(SCREEN_HEIGHT): pixel y to the safe-zone map.
- `i_is_safe` in 1: combinational map answer for the current query.
- `o_busy` out 1: check in progress.
- `o_check_valid` out 1: one-cycle pulse when a check completes.
- `o_on_safe` out 1: result of the last completed check; held between checks.
- `o_dead` out 1: one-cycle death pulse.

## Operation
- **States:** IDLE, Q0, S0, Q1, S1, Q2, S2, Q3, S3, DONE.
- **IDLE:** on `i_frame_tick`:
  - If `i_zone_rdy` = 1, capture the player position and go to Q0.
  - If `i_zone_rdy` = 0, stay in IDLE and clear the unsafe counter. The player is not penalised during regeneration.
- **Corners k = 0..3:** TL, TR, BL, BR.
  - x1 = min(px + PLAYER_SIZE − 1, SCREEN_WIDTH − 1).
  - y1 = min(py + PLAYER_SIZE − 1, SCREEN_HEIGHT − 1).
  - Compute the sum one bit wider than the position, then clamp.
- **Qk:** register corner k onto `o_query_x/y`.
- **Sk:** hold the query and sample `i_is_safe` at the end of the cycle. AND it into `all_safe`, which is set to 1 on entry to Q0.
- **DONE:**
  - Pulse `o_check_valid` and set `o_on_safe` = `all_safe`.
  - If safe, clear the unsafe counter.
  - If unsafe, increment the counter. When the incremented value equals DEATH_FRAMES, pulse `o_dead` and clear the counter.
  - Return to IDLE.
- **Counter:** width clog2(DEATH_FRAMES+1); it never exceeds DEATH_FRAMES − 1 at rest.
- **`i_frame_tick` outside IDLE:** ignored; no queueing.
- **`i_zone_rdy` falling in any Q/S state:** abort to IDLE next cycle. No `o_check_valid`, no change to `o_on_safe` or the counter.
- **`i_frame_tick` and `i_zone_rdy` fall in the same IDLE cycle:** treated as "not ready" (counter clear).
- **Position changes mid-check:** no effect; the captured copy is used.

## Timing
- **Reset values:** state IDLE; `o_busy` = 0, `o_check_valid` = 0, `o_dead` = 0, `o_on_safe` = 1, `o_query_x/y` = 0, counter = 0.
- **Tick accepted at edge T:**
  - `o_busy` = 1 in cycles T+1..T+9.
  - Corner k is on the query port in cycles T+1+2k and T+2+2k.
  - `o_check_valid`, `o_dead` and `o_on_safe` are updated at T+9.
  - IDLE at T+10.
- **Latency:** 9 cycles tick-to-result. A new tick is accepted from T+10 onward.
- **Query outputs:** hold their last value in IDLE.
- **Reset mid-check:** returns to reset values on the next edge.

## Structure
- **Shared package `zone_check_pkg`:** the state enum `zc_state_t`, the corner index type `corner_t` (2 bits), and the corner order constants.
- **Sub-module:** none; the clamp adders and corner mux are small and stay in the block.
- **Width rules:** derived from SCREEN_WIDTH/SCREEN_HEIGHT with `$clog2` to match the safe-zone map port widths.

## Test plan
- **All safe:** `i_is_safe` tied 1, tick with player (100,100) → queries (100,100), (119,100), (100,119), (119,119) in order; `o_check_valid` at T+9; `o_on_safe` = 1; no `o_dead`.
- **Single unsafe corner:** `i_is_safe` = 0 only for (119,119) → `o_on_safe` = 0; counter = 1; no death. Repeat two more ticks → `o_dead` pulses exactly once on the third; counter back to 0.
- **Recovery:** unsafe, unsafe, safe, unsafe, unsafe → no `o_dead` (counter cleared by the safe frame).
- **Edge clamp:** player (790,590) → TR/BR x = 799, BL/BR y = 599.
- **Regeneration:** drop `i_zone_rdy` at cycle T+4 → abort; no `o_check_valid`; `o_on_safe` unchanged. Tick with `i_zone_rdy` = 0 → counter cleared, `o_busy` stays 0.
- **Overlap and reset:** tick at T+3 during a check is ignored (exactly one `o_check_valid`). `arst_n` low at T+5 → all outputs at reset values next cycle.
